mips_multicycle_control: RTL and testbench
==========================================

Name: mips_multicycle_control

Overview:
- Main control FSM for the multicycle MIPS datapath; sits directly upstream of the ALU control unit.
- Decodes the 6-bit opcode of the instruction register and sequences fetch/decode/execute/memory/writeback.
- Drives all datapath enables, muxes and the 2-bit alu_op consumed by the ALU control unit.
  - alu_op 00 = add, 01 = subtract (beq), 10 = decode funct.
- Moore FSM with one handshake input (mem_ready) for variable-latency memory.

Parameters:
- STATE_W, 4, width of state register and debug state port (minimum 4).

Ports:
- clk  input  1  system clock, all state updates on rising edge
- reset  input  1  asynchronous, active-high; forces state IDLE
- opcode  input  6  instruction[31:26] from instruction register
- mem_ready  input  1  memory access completes this cycle
- pc_write  output  1  unconditional PC load
- pc_write_cond  output  1  PC load if ALU zero (beq)
- i_or_d  output  1  memory address select: 0 = PC, 1 = ALUOut
- mem_read  output  1  memory read strobe
- mem_write  output  1  memory write strobe
- ir_write  output  1  instruction register load
- mem_to_reg  output  1  regfile write data: 0 = ALUOut, 1 = MDR
- reg_dst  output  1  regfile dest: 0 = rt, 1 = rd
- reg_write  output  1  regfile write enable
- alu_src_a  output  1  0 = PC, 1 = register A
- alu_src_b  output  2  00 = B, 01 = constant 4, 10 = sign-ext imm, 11 = sign-ext imm << 2
- alu_op  output  2  to ALU control unit
- pc_source  output  2  00 = ALU result, 01 = ALUOut, 10 = jump target
- illegal_op  output  1  unsupported opcode trapped
- state  output  STATE_W  current state (debug)

Behaviour:
- Reset (async, any time, including mid-instruction or mid-memory-wait):
  - state = IDLE; every output 0; alu_op = 00.
  - First rising edge after reset deasserts: IDLE -> FETCH.
- FETCH:
  - mem_read = 1, i_or_d = 0, alu_src_a = 0, alu_src_b = 01, alu_op = 00, pc_source = 00.
  - ir_write and pc_write = mem_ready (qualified, so no IR/PC update while waiting).
  - mem_ready = 0: stay in FETCH. mem_ready = 1: go to DECODE.
- DECODE: alu_src_a = 0, alu_src_b = 11, alu_op = 00 (branch target into ALUOut). Next state by opcode:
  - 000000 -> RTYPE_EXEC
  - 100011 or 101011 -> MEM_ADDR
  - 000100 -> BEQ
  - 000010 -> JUMP
  - 001000 -> ADDI_EXEC
  - anything else -> HALT
- MEM_ADDR: alu_src_a = 1, alu_src_b = 10, alu_op = 00. lw -> MEM_READ; sw -> MEM_WRITE.
- MEM_READ: mem_read = 1, i_or_d = 1. Holds until mem_ready = 1, then -> MEM_WB.
- MEM_WB: reg_write = 1, mem_to_reg = 1, reg_dst = 0 -> FETCH.
- MEM_WRITE: mem_write = 1, i_or_d = 1. Holds until mem_ready = 1, then -> FETCH.
- RTYPE_EXEC: alu_src_a = 1, alu_src_b = 00, alu_op = 10 -> RTYPE_WB.
- RTYPE_WB: reg_write = 1, reg_dst = 1, mem_to_reg = 0 -> FETCH.
- BEQ: alu_src_a = 1, alu_src_b = 00, alu_op = 01, pc_write_cond = 1, pc_source = 01 -> FETCH.
- JUMP: pc_write = 1, pc_source = 10 -> FETCH.
- ADDI_EXEC: alu_src_a = 1, alu_src_b = 10, alu_op = 00 -> ADDI_WB.
- ADDI_WB: reg_write = 1, reg_dst = 0, mem_to_reg = 0 -> FETCH.
- HALT: illegal_op = 1, all other outputs 0. Stays in HALT until reset.
- Any output not listed for a state is 0.
- Opcode is sampled only in DECODE and MEM_ADDR; changes on opcode in other states are ignored.
- Cycle counts with mem_ready = 1 throughout (cycles from FETCH entry back to FETCH):
  - R-type 4, lw 5, sw 4, beq 3, j 3, addi 4.
  - Each cycle with mem_ready = 0 adds one cycle.
- Unused state encodings go to HALT.

Optional Feature:
- Macro: MC_ADDI_EN
- Defined: ADDI_EXEC/ADDI_WB exist and opcode 001000 decodes to ADDI_EXEC as above.
- Undefined: both states are removed and opcode 001000 decodes to HALT with illegal_op = 1.

Test Plan:
- Release reset, mem_ready = 1, opcode = 000000 -> states IDLE, FETCH, DECODE, RTYPE_EXEC (alu_op = 10), RTYPE_WB (reg_write = 1, reg_dst = 1), then FETCH; 4 cycles per instruction.
- opcode = 100011, mem_ready low for 3 cycles in MEM_READ -> MEM_READ held 4 cycles with mem_read = 1, i_or_d = 1, then MEM_WB with reg_write = 1, mem_to_reg = 1.
- FETCH with mem_ready = 0 for 2 cycles -> ir_write = 0 and pc_write = 0 while waiting; both 1 only in the mem_ready = 1 cycle.
- opcode = 000100 -> BEQ drives alu_op = 01, pc_write_cond = 1, pc_source = 01; opcode = 000010 -> JUMP drives pc_write = 1, pc_source = 10.
- opcode = 111111 (and 001000 with MC_ADDI_EN undefined) -> HALT, illegal_op = 1 held for 10+ cycles; reset returns to IDLE with illegal_op = 0.
- Assert reset during MEM_WRITE with mem_write = 1 -> mem_write and all other outputs 0 immediately, before any clock edge; state = IDLE.

Source files
------------

// File: rtl/mips_multicycle_control.sv
// Main control FSM for the multicycle MIPS datapath (fetch/decode/execute/mem/writeback).
// Define MC_ADDI_EN to include the addi execute/writeback states; otherwise addi traps to HALT.
module mips_multicycle_control #(
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [5:0]         opcode,
    input  logic               mem_ready,
    output logic               pc_write,
    output logic               pc_write_cond,
    output logic               i_or_d,
    output logic               mem_read,
    output logic               mem_write,
    output logic               ir_write,
    output logic               mem_to_reg,
    output logic               reg_dst,
    output logic               reg_write,
    output logic               alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [1:0]         alu_op,
    output logic [1:0]         pc_source,
    output logic               illegal_op,
    output logic [STATE_W-1:0] state
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
`ifdef MC_ADDI_EN
    localparam logic [5:0] OP_ADDI  = 6'b001000;
`endif

    typedef enum logic [STATE_W-1:0] {
        IDLE       = STATE_W'(0),
        FETCH      = STATE_W'(1),
        DECODE     = STATE_W'(2),
        MEM_ADDR   = STATE_W'(3),
        MEM_READ   = STATE_W'(4),
        MEM_WB     = STATE_W'(5),
        MEM_WRITE  = STATE_W'(6),
        RTYPE_EXEC = STATE_W'(7),
        RTYPE_WB   = STATE_W'(8),
        BEQ        = STATE_W'(9),
        JUMP       = STATE_W'(10),
`ifdef MC_ADDI_EN
        ADDI_EXEC  = STATE_W'(11),
        ADDI_WB    = STATE_W'(12),
`endif
        HALT       = STATE_W'(13)
    } state_t;

    state_t state_q;
    state_t state_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    assign state = state_q;

    // Outputs are a function of the current state only, except the fetch-time
    // IR/PC loads which are qualified by mem_ready so a stalled fetch updates nothing.
    always_comb begin
        state_d       = state_q;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_op        = 2'b00;
        pc_source     = 2'b00;
        illegal_op    = 1'b0;

        case (state_q)
            IDLE: begin
                state_d = FETCH;
            end
            FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
                if (mem_ready) begin
                    state_d = DECODE;
                end
            end
            DECODE: begin
                alu_src_b = 2'b11;
                case (opcode)
                    OP_RTYPE:     state_d = RTYPE_EXEC;
                    OP_LW, OP_SW: state_d = MEM_ADDR;
                    OP_BEQ:       state_d = BEQ;
                    OP_J:         state_d = JUMP;
`ifdef MC_ADDI_EN
                    OP_ADDI:      state_d = ADDI_EXEC;
`endif
                    default:      state_d = HALT;
                endcase
            end
            MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                // Opcode is re-sampled here; anything but lw/sw at this point is trapped.
                if (opcode == OP_SW) begin
                    state_d = MEM_WRITE;
                end else if (opcode == OP_LW) begin
                    state_d = MEM_READ;
                end else begin
                    state_d = HALT;
                end
            end
            MEM_READ: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
                if (mem_ready) begin
                    state_d = MEM_WB;
                end
            end
            MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                state_d    = FETCH;
            end
            MEM_WRITE: begin
                mem_write = 1'b1;
                i_or_d    = 1'b1;
                if (mem_ready) begin
                    state_d = FETCH;
                end
            end
            RTYPE_EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b10;
                state_d   = RTYPE_WB;
            end
            RTYPE_WB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
                state_d   = FETCH;
            end
            BEQ: begin
                alu_src_a     = 1'b1;
                alu_op        = 2'b01;
                pc_write_cond = 1'b1;
                pc_source     = 2'b01;
                state_d       = FETCH;
            end
            JUMP: begin
                pc_write  = 1'b1;
                pc_source = 2'b10;
                state_d   = FETCH;
            end
`ifdef MC_ADDI_EN
            ADDI_EXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                state_d   = ADDI_WB;
            end
            ADDI_WB: begin
                reg_write = 1'b1;
                state_d   = FETCH;
            end
`endif
            HALT: begin
                illegal_op = 1'b1;
                state_d    = HALT;
            end
            default: begin
                state_d = HALT;
            end
        endcase
    end

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Bench for mips_multicycle_control: instruction-sequence reference model, cycle-count
// table, directed corner cases (memory stalls, HALT, async reset) and random opcodes.
module tb_mips_multicycle_control;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
    logic       mem_to_reg, reg_dst, reg_write, alu_src_a, illegal_op;
    logic [1:0] alu_src_b, alu_op, pc_source;
    logic [3:0] state;

    mips_multicycle_control #(.STATE_W(4)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
        .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .pc_source(pc_source), .illegal_op(illegal_op), .state(state)
    );

    always #5 clk = ~clk;

`ifdef MC_ADDI_EN
    localparam bit ADDI_EN = 1'b1;
`else
    localparam bit ADDI_EN = 1'b0;
`endif

    // Micro-steps of an instruction, as the reference model sees them.
    typedef enum logic [3:0] {
        K_IDLE, K_FETCH, K_DECODE, K_ADDR, K_MRD, K_MWB, K_MWR,
        K_REX, K_RWB, K_BEQ, K_J, K_AEX, K_AWB, K_HALT
    } kind_t;

    typedef struct {
        logic [5:0] op;
        int         cycles;
        string      name;
    } vec_t;

    kind_t      cur;
    kind_t      pend[$];
    logic [5:0] dec_op;
    logic       last_irw;
    int         total = 0;
    int         bad = 0;

    function automatic logic [16:0] pack(logic pcw, logic pcwc, logic iod, logic mrd,
                                         logic mwr, logic irw, logic m2r, logic rdst,
                                         logic rw, logic asa, logic [1:0] asb,
                                         logic [1:0] aop, logic [1:0] psrc, logic ill);
        return {pcw, pcwc, iod, mrd, mwr, irw, m2r, rdst, rw, asa, asb, aop, psrc, ill};
    endfunction

    function automatic logic [16:0] exp_out(kind_t k, logic mr);
        case (k)
            K_FETCH:  return pack(mr, 0, 0, 1, 0, mr, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 0);
            K_DECODE: return pack(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b00, 2'b00, 0);
            K_ADDR:   return pack(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 2'b00, 0);
            K_MRD:    return pack(0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0);
            K_MWB:    return pack(0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 2'b00, 2'b00, 2'b00, 0);
            K_MWR:    return pack(0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0);
            K_REX:    return pack(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b10, 2'b00, 0);
            K_RWB:    return pack(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 0);
            K_BEQ:    return pack(0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b01, 2'b01, 0);
            K_J:      return pack(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b10, 0);
            K_AEX:    return pack(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 2'b00, 0);
            K_AWB:    return pack(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 2'b00, 0);
            K_HALT:   return pack(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 1);
            default:  return 17'd0;
        endcase
    endfunction

    function automatic logic [16:0] dut_out();
        return {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
                mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
                pc_source, illegal_op};
    endfunction

    task automatic check(string nm, logic [16:0] got, logic [16:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %b expected %b (t=%0t)", nm, got, exp, $time);
        end
    endtask

    // Advance the model one clock: a decoded instruction becomes a list of steps,
    // memory steps repeat until mem_ready, and an empty list means back to fetch.
    task automatic model_step(logic [5:0] op, logic mr);
        case (cur)
            K_IDLE:  cur = K_FETCH;
            K_FETCH: if (mr) cur = K_DECODE;
            K_HALT:  cur = K_HALT;
            K_DECODE: begin
                dec_op = op;
                if (op == 6'b000000)                pend = '{K_REX, K_RWB};
                else if (op == 6'b100011)           pend = '{K_ADDR, K_MRD, K_MWB};
                else if (op == 6'b101011)           pend = '{K_ADDR, K_MWR};
                else if (op == 6'b000100)           pend = '{K_BEQ};
                else if (op == 6'b000010)           pend = '{K_J};
                else if (op == 6'b001000 && ADDI_EN) pend = '{K_AEX, K_AWB};
                else                                pend = '{K_HALT};
                cur = pend.pop_front();
            end
            default: begin
                if (!((cur == K_MRD || cur == K_MWR) && !mr)) begin
                    if (pend.size() == 0) cur = K_FETCH;
                    else cur = pend.pop_front();
                end
            end
        endcase
    endtask

    task automatic applyStimulus(logic [5:0] op, logic mr, logic rst, string nm);
        @(negedge clk);
        reset = rst;
        opcode = op;
        mem_ready = mr;
        if (rst) begin
            cur = K_IDLE;
            pend.delete();
        end
        #1;
        check(nm, dut_out(), exp_out(cur, mr));
        last_irw = ir_write;
        if (!rst) model_step(op, mr);
    endtask

    task automatic checkOutput(string nm, logic got, logic exp);
        check(nm, {16'd0, got}, {16'd0, exp});
    endtask

    initial begin
        vec_t vecs[$];
        int   n;
        int   hc;
        logic [5:0] op;
        logic mr;
        logic rst;

        reset = 1'b1;
        opcode = 6'd0;
        mem_ready = 1'b1;
        cur = K_IDLE;
        last_irw = 1'b0;
        dec_op = 6'd0;

        vecs.push_back('{6'b000000, 4, "rtype"});
        vecs.push_back('{6'b100011, 5, "lw"});
        vecs.push_back('{6'b101011, 4, "sw"});
        vecs.push_back('{6'b000100, 3, "beq"});
        vecs.push_back('{6'b000010, 3, "j"});
        if (ADDI_EN) vecs.push_back('{6'b001000, 4, "addi"});
        vecs.push_back('{6'b000000, 4, "rtype2"});

        applyStimulus(6'd0, 1'b1, 1'b1, "reset_outputs");
        applyStimulus(6'd0, 1'b1, 1'b1, "reset_outputs_held");
        applyStimulus(6'd0, 1'b1, 1'b0, "idle");
        applyStimulus(6'd0, 1'b1, 1'b0, "first_fetch");

        // Each entry starts just after a completed fetch and ends after the next one.
        foreach (vecs[i]) begin
            n = 1;
            while (n < 20) begin
                applyStimulus(vecs[i].op, 1'b1, 1'b0, vecs[i].name);
                if (last_irw) break;
                n++;
            end
            check({vecs[i].name, "_cycles"}, 17'(n), 17'(vecs[i].cycles));
        end

        // lw with a three-cycle memory stall in the read.
        applyStimulus(6'b100011, 1'b1, 1'b0, "lw_decode");
        applyStimulus(6'b100011, 1'b1, 1'b0, "lw_addr");
        for (int i = 0; i < 3; i++) begin
            applyStimulus(6'b100011, 1'b0, 1'b0, "lw_stall");
            checkOutput("lw_stall_mem_read", mem_read, 1'b1);
            checkOutput("lw_stall_i_or_d", i_or_d, 1'b1);
        end
        applyStimulus(6'b100011, 1'b1, 1'b0, "lw_read_done");
        applyStimulus(6'b111111, 1'b1, 1'b0, "lw_wb");
        checkOutput("lw_wb_reg_write", reg_write, 1'b1);
        checkOutput("lw_wb_mem_to_reg", mem_to_reg, 1'b1);

        // Stalled fetch must not load IR or PC.
        for (int i = 0; i < 2; i++) begin
            applyStimulus(6'b000100, 1'b0, 1'b0, "fetch_stall");
            checkOutput("fetch_stall_ir_write", ir_write, 1'b0);
            checkOutput("fetch_stall_pc_write", pc_write, 1'b0);
        end
        applyStimulus(6'b000100, 1'b1, 1'b0, "fetch_done");
        checkOutput("fetch_done_ir_write", ir_write, 1'b1);
        checkOutput("fetch_done_pc_write", pc_write, 1'b1);

        applyStimulus(6'b000100, 1'b1, 1'b0, "beq_decode");
        applyStimulus(6'b000000, 1'b1, 1'b0, "beq_exec");
        check("beq_alu_op", {15'd0, alu_op}, 17'd1);
        checkOutput("beq_pc_write_cond", pc_write_cond, 1'b1);
        check("beq_pc_source", {15'd0, pc_source}, 17'd1);
        applyStimulus(6'b000010, 1'b1, 1'b0, "j_fetch");
        applyStimulus(6'b000010, 1'b1, 1'b0, "j_decode");
        applyStimulus(6'b100011, 1'b1, 1'b0, "j_exec");
        checkOutput("j_pc_write", pc_write, 1'b1);
        check("j_pc_source", {15'd0, pc_source}, 17'd2);

        // Async reset while a store is waiting on memory.
        applyStimulus(6'b101011, 1'b1, 1'b0, "sw_fetch");
        applyStimulus(6'b101011, 1'b1, 1'b0, "sw_decode");
        applyStimulus(6'b101011, 1'b1, 1'b0, "sw_addr");
        applyStimulus(6'b101011, 1'b0, 1'b0, "sw_wait");
        checkOutput("sw_wait_mem_write", mem_write, 1'b1);
        #1;
        reset = 1'b1;
        #1;
        check("async_reset_outputs", dut_out(), 17'd0);
        applyStimulus(6'b101011, 1'b0, 1'b1, "reset_after_sw");

        // Illegal opcodes trap until reset.
        begin
            logic [5:0] illegal [$];
            illegal.push_back(6'b111111);
            if (!ADDI_EN) illegal.push_back(6'b001000);
            foreach (illegal[k]) begin
                applyStimulus(6'd0, 1'b1, 1'b0, "halt_idle");
                applyStimulus(6'd0, 1'b1, 1'b0, "halt_fetch");
                applyStimulus(illegal[k], 1'b1, 1'b0, "halt_decode");
                for (int i = 0; i < 12; i++) begin
                    applyStimulus(6'(i), i[0], 1'b0, "halt_hold");
                    checkOutput("halt_illegal_op", illegal_op, 1'b1);
                end
                applyStimulus(6'd0, 1'b1, 1'b1, "halt_reset");
                checkOutput("halt_reset_illegal_op", illegal_op, 1'b0);
            end
        end

        // Random opcodes and memory latency; opcode held steady through the address step.
        hc = 0;
        for (int i = 0; i < 800; i++) begin
            case ($urandom_range(0, 9))
                0, 1, 2: op = 6'b000000;
                3, 8:    op = 6'b100011;
                4:       op = 6'b101011;
                5:       op = 6'b000100;
                6:       op = 6'b000010;
                7:       op = 6'b001000;
                default: op = 6'($urandom);
            endcase
            if (cur == K_ADDR) op = dec_op;
            mr = ($urandom_range(0, 3) != 0);
            rst = (cur == K_HALT && hc >= 4) || ($urandom_range(0, 199) == 0);
            if (cur == K_HALT) hc++;
            if (rst) hc = 0;
            applyStimulus(op, mr, rst, "random");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
